// File: rtl/tinyalu_pkg.sv
// Shared types for the tiny ALU: opcodes, packed operand pair, FSM states,
// default multiply latency and an opcode classification helper.
package tinyalu_pkg;

    localparam int MUL_LATENCY_DEF = 3;

    typedef enum logic [2:0] {
        no_op    = 3'b000,
        add_op   = 3'b001,
        and_op   = 3'b010,
        xor_op   = 3'b011,
        mul_op   = 3'b100,
        unused_5 = 3'b101,
        unused_6 = 3'b110,
        rst_op   = 3'b111
    } operation_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } operandAB_T;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Only these opcodes leave IDLE; everything else is swallowed silently.
    function automatic logic is_exec(input operation_t op);
        return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
    endfunction

endpackage

// File: rtl/tiny_alu_mult.sv
// Registered 8x8->16 multiplier with STAGES pipeline registers; the first
// stage holds the product, the rest only add delay.
module tiny_alu_mult #(
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    logic [15:0] pipe [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= 16'(a) * 16'(b);
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign product = pipe[STAGES-1];

endmodule

// File: rtl/tiny_alu_core.sv
// Tiny ALU command engine: accepts one command in IDLE, completes it after a
// fixed latency with a registered done pulse and result.
//   state | meaning
//   IDLE  | waiting for start; latches op/operands on acceptance
//   BUSY  | latency down-counter running; start=0 aborts
//   DONE  | done=1 for one cycle, start ignored
module tiny_alu_core
    import tinyalu_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  operation_t  op,
    input  operandAB_T  operands,
    output logic        done,
    output logic [15:0] result
);

    localparam int CNT_W = 3;

    alu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    operation_t       op_q, op_nxt;
    operandAB_T       opnd_q, opnd_nxt;
    logic             done_nxt;
    logic [15:0]      result_nxt;
    logic [15:0]      alu_out;
    logic [15:0]      product;

    // Operands come from the latched copy, so the pipeline sees stable
    // inputs for the whole BUSY window regardless of the bus.
    tiny_alu_mult #(
        .STAGES (MUL_LATENCY - 1)
    ) u_mult (
        .clk     (clk),
        .rst     (reset),
        .a       (opnd_q.a),
        .b       (opnd_q.b),
        .product (product)
    );

    always_comb begin
        alu_out = result;
        case (op_q)
            add_op:  alu_out = {7'b0, {1'b0, opnd_q.a} + {1'b0, opnd_q.b}};
            and_op:  alu_out = {8'b0, opnd_q.a & opnd_q.b};
            xor_op:  alu_out = {8'b0, opnd_q.a ^ opnd_q.b};
            mul_op:  alu_out = product;
            default: alu_out = result;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        opnd_nxt   = opnd_q;
        done_nxt   = 1'b0;
        result_nxt = result;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt   = op;
                    opnd_nxt = operands;
                    if (is_exec(op)) begin
                        state_nxt = BUSY;
                        cnt_nxt   = (op == mul_op) ? CNT_W'(MUL_LATENCY - 1) : '0;
                    end
                end
            end
            BUSY: begin
                if (!start) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt  = DONE;
                    done_nxt   = 1'b1;
                    result_nxt = alu_out;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= no_op;
            opnd_q <= '0;
            done   <= 1'b0;
            result <= 16'h0000;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_q   <= op_nxt;
            opnd_q <= opnd_nxt;
            done   <= done_nxt;
            result <= result_nxt;
        end
    end

endmodule

// File: tb/tb_tiny_alu_core.sv
// Directed bench for tiny_alu_core: vector table plus hand sequences for
// back-to-back, abort and asynchronous reset cases.
module tb_tiny_alu_core;
    import tinyalu_pkg::*;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    operation_t  op;
    operandAB_T  operands;
    logic        done;
    logic [15:0] result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        operation_t  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        exp_done;
        int          exp_lat;
        logic [15:0] exp_result;
    } vec_t;

    vec_t tbl [14];

    tiny_alu_core #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .operands (operands),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drives one command and watches up to 12 edges; k=1 is the acceptance edge.
    task automatic run_vec(input vec_t v, input bit no_wait);
        bit          found;
        int          lat;
        logic [15:0] res;
        found = 0;
        lat   = 0;
        res   = '0;
        if (!no_wait) @(negedge clk);
        op       = v.op;
        operands = {v.a, v.b};
        start    = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (!v.exp_done && k == 1) start = 1'b0;
            if (done && !found) begin
                found = 1;
                lat   = k - 1;
                res   = result;
                start = 1'b0;
                break;
            end
        end
        if (v.exp_done) begin
            check("done_seen", 32'(found), 32'd1);
            check("latency", 32'(lat), 32'(v.exp_lat));
            check("result", 32'(res), 32'(v.exp_result));
            @(posedge clk);
            #1;
            check("done_single_pulse", 32'(done), 32'd0);
        end else begin
            check("no_done", 32'(found), 32'd0);
            check("result_hold", 32'(result), 32'(v.exp_result));
        end
    endtask

    initial begin
        bit found;

        tbl[0]  = '{add_op,   8'hFF, 8'h01, 1'b1, 1,       16'h0100};
        tbl[1]  = '{mul_op,   8'hFF, 8'hFF, 1'b1, MUL_LAT, 16'hFE01};
        tbl[2]  = '{xor_op,   8'hA5, 8'h0F, 1'b1, 1,       16'h00AA};
        tbl[3]  = '{and_op,   8'hF0, 8'h3C, 1'b1, 1,       16'h0030};
        tbl[4]  = '{no_op,    8'h12, 8'h34, 1'b0, 0,       16'h0030};
        tbl[5]  = '{unused_5, 8'h12, 8'h34, 1'b0, 0,       16'h0030};
        tbl[6]  = '{add_op,   8'h80, 8'h80, 1'b1, 1,       16'h0100};
        tbl[7]  = '{mul_op,   8'h00, 8'h55, 1'b1, MUL_LAT, 16'h0000};
        tbl[8]  = '{rst_op,   8'hAA, 8'h55, 1'b0, 0,       16'h0000};
        tbl[9]  = '{unused_6, 8'h01, 8'h01, 1'b0, 0,       16'h0000};
        tbl[10] = '{mul_op,   8'h0F, 8'h11, 1'b1, MUL_LAT, 16'h00FF};
        tbl[11] = '{add_op,   8'h00, 8'h00, 1'b1, 1,       16'h0000};
        tbl[12] = '{xor_op,   8'hFF, 8'hFF, 1'b1, 1,       16'h0000};
        tbl[13] = '{and_op,   8'hFF, 8'hFF, 1'b1, 1,       16'h00FF};

        reset    = 1'b1;
        start    = 1'b0;
        op       = no_op;
        operands = '0;
        #22;
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'h0);

        // First command goes in on the very first edge after release.
        @(negedge clk);
        reset = 1'b0;
        run_vec(tbl[0], 1'b1);
        for (int i = 1; i < 14; i++) run_vec(tbl[i], 1'b0);

        // Back-to-back: start held through DONE, new op presented during DONE.
        @(negedge clk);
        op = xor_op; operands = {8'hA5, 8'h0F}; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b_first_done", 32'(done), 32'd1);
        check("b2b_first_result", 32'(result), 32'h00AA);
        op = and_op; operands = {8'hF0, 8'h3C};
        @(posedge clk); #1;
        check("b2b_done_drop", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("b2b_accept_edge", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("b2b_second_done", 32'(done), 32'd1);
        check("b2b_second_result", 32'(result), 32'h0030);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_second_single", 32'(done), 32'd0);

        // Multiply aborted by dropping start during BUSY.
        @(negedge clk);
        op = mul_op; operands = {8'h12, 8'h34}; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) found = 1;
        end
        check("abort_no_done", 32'(found), 32'd0);
        check("abort_result_hold", 32'(result), 32'h0030);
        run_vec('{add_op, 8'h02, 8'h03, 1'b1, 1, 16'h0005}, 1'b0);

        // Asynchronous reset between edges during a multiply.
        @(negedge clk);
        op = mul_op; operands = {8'hFF, 8'hFF}; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_result", 32'(result), 32'h0);
        check("async_rst_done", 32'(done), 32'd0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        found = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) found = 1;
        end
        check("rst_release_no_done", 32'(found), 32'd0);
        check("rst_release_result", 32'(result), 32'h0);

        // Asynchronous reset while done is high clears it immediately.
        @(negedge clk);
        op = add_op; operands = {8'h03, 8'h04}; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_done", 32'(done), 32'd1);
        check("pre_rst_result", 32'(result), 32'h0007);
        #2;
        reset = 1'b1;
        #1;
        check("rst_clears_done", 32'(done), 32'd0);
        check("rst_clears_result", 32'(result), 32'h0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
